// File: rtl/vec_pkg.sv
// Shared constants, types and helpers for the multi-cycle vector ALU.
package vec_pkg;

  localparam int unsigned ELEM_W    = 32;
  localparam int unsigned VLEN      = 512;
  localparam int unsigned NUM_LANES = VLEN / ELEM_W;
  localparam int unsigned LaneW     = $clog2(NUM_LANES);

  typedef logic [NUM_LANES-1:0][ELEM_W-1:0] vec_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  // MUL needs two distinct destinations since both halves are written in the same cycle.
  function automatic logic req_illegal(op_e op, logic [1:0] dst_lo, logic [1:0] dst_hi);
    return (op == OP_RSVD) || ((op == OP_MUL) && (dst_lo == dst_hi));
  endfunction

  function automatic vec_t pick_reg(logic [1:0] idx, vec_t r0, vec_t r1, vec_t r2, vec_t r3);
    vec_t r;
    unique case (idx)
      2'd0: r = r0;
      2'd1: r = r1;
      2'd2: r = r2;
      2'd3: r = r3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vec_alu_seq_if.sv
// Request, register-file read and register-file write bundle of the vector ALU.
interface vec_alu_seq_if;
  import vec_pkg::*;

  logic            start;
  logic [1:0]      opcode;
  logic [1:0]      src_a;
  logic [1:0]      src_b;
  logic [1:0]      dst_lo;
  logic [1:0]      dst_hi;
  logic [VLEN-1:0] A1;
  logic [VLEN-1:0] A2;
  logic [VLEN-1:0] A3;
  logic [VLEN-1:0] A4;
  logic [VLEN-1:0] input_data_1;
  logic [VLEN-1:0] input_data_2;
  logic [1:0]      write_address_1;
  logic [1:0]      write_address_2;
  logic            write_enable_1;
  logic            write_enable_2;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output start, opcode, src_a, src_b, dst_lo, dst_hi, A1, A2, A3, A4,
    input  input_data_1, input_data_2, write_address_1, write_address_2,
           write_enable_1, write_enable_2, busy, done, err
  );

  modport slave (
    input  start, opcode, src_a, src_b, dst_lo, dst_hi, A1, A2, A3, A4,
    output input_data_1, input_data_2, write_address_1, write_address_2,
           write_enable_1, write_enable_2, busy, done, err
  );

endinterface

// File: rtl/vec_lane_alu.sv
// One signed 32-bit lane: ADD/SUB wrap into lo, MUL splits the 64-bit product over lo/hi.
module vec_lane_alu
  import vec_pkg::*;
(
  input  logic [ELEM_W-1:0] a_i,
  input  logic [ELEM_W-1:0] b_i,
  input  op_e               op_i,
  output logic [ELEM_W-1:0] lo_o,
  output logic [ELEM_W-1:0] hi_o
);

  logic [2*ELEM_W-1:0] prod;

  // Sign-extend first so the unsigned 64-bit product equals the signed one.
  assign prod = {{ELEM_W{a_i[ELEM_W-1]}}, a_i} * {{ELEM_W{b_i[ELEM_W-1]}}, b_i};

  always_comb begin
    lo_o = '0;
    hi_o = '0;
    unique case (op_i)
      OP_ADD:  lo_o = a_i + b_i;
      OP_SUB:  lo_o = a_i - b_i;
      OP_MUL: begin
        lo_o = prod[ELEM_W-1:0];
        hi_o = prod[2*ELEM_W-1:ELEM_W];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Multi-cycle elementwise vector ALU: snapshot two registers, compute LANES_PER_BEAT lanes
// per cycle, then write results back through the register file's two write ports.
module vec_alu_seq
  import vec_pkg::*;
#(
  parameter int unsigned LANES_PER_BEAT = 4
) (
  input logic          clk,
  input logic          reset,
  vec_alu_seq_if.slave vec_io
);

  localparam int unsigned BEATS = NUM_LANES / LANES_PER_BEAT;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e           state_q, state_d;
  op_e              op_q, req_op;
  logic [1:0]       dst_lo_q, dst_hi_q;
  logic [BeatW-1:0] beat_q, beat_d;
  vec_t             opa_q, opb_q;
  vec_t             res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             accept, reject, last_beat;

  logic             we1_d, we2_d, busy_d, err_d;
  logic             we1_q, we2_q, busy_q, done_q, err_q;
  logic [1:0]       wa1_d, wa2_d, wa1_q, wa2_q;
  vec_t             wd1_d, wd2_d, wd1_q, wd2_q;

  logic [LaneW-1:0]  lane_idx [LANES_PER_BEAT];
  logic [ELEM_W-1:0] lane_lo  [LANES_PER_BEAT];
  logic [ELEM_W-1:0] lane_hi  [LANES_PER_BEAT];

  assign req_op    = op_e'(vec_io.opcode);
  assign accept    = (state_q == S_IDLE) && vec_io.start &&
                     !req_illegal(req_op, vec_io.dst_lo, vec_io.dst_hi);
  assign reject    = (state_q == S_IDLE) && vec_io.start &&
                     req_illegal(req_op, vec_io.dst_lo, vec_io.dst_hi);
  assign last_beat = (beat_q == BeatW'(BEATS - 1));

  for (genvar j = 0; j < LANES_PER_BEAT; j++) begin : g_lane
    assign lane_idx[j] = LaneW'(int'(beat_q) * int'(LANES_PER_BEAT) + j);

    vec_lane_alu u_lane (
      .a_i  (opa_q[lane_idx[j]]),
      .b_i  (opb_q[lane_idx[j]]),
      .op_i (op_q),
      .lo_o (lane_lo[j]),
      .hi_o (lane_hi[j])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  if (last_beat) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    beat_d   = beat_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    if (accept) begin
      beat_d = '0;
    end else if (state_q == S_EXEC) begin
      beat_d = beat_q + 1'b1;
      for (int j = 0; j < int'(LANES_PER_BEAT); j++) begin
        res_lo_d[lane_idx[j]] = lane_lo[j];
        res_hi_d[lane_idx[j]] = lane_hi[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_ADD;
      dst_lo_q <= '0;
      dst_hi_q <= '0;
      beat_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      beat_q   <= beat_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      if (accept) begin
        op_q     <= req_op;
        dst_lo_q <= vec_io.dst_lo;
        dst_hi_q <= vec_io.dst_hi;
        opa_q    <= pick_reg(vec_io.src_a, vec_io.A1, vec_io.A2, vec_io.A3, vec_io.A4);
        opb_q    <= pick_reg(vec_io.src_b, vec_io.A1, vec_io.A2, vec_io.A3, vec_io.A4);
      end
    end
  end

  // Outputs are registered from the next state so they are valid for the whole WB cycle.
  always_comb begin
    we1_d  = (state_d == S_WB);
    we2_d  = we1_d && (op_q == OP_MUL);
    wa1_d  = we1_d ? dst_lo_q : '0;
    wa2_d  = we2_d ? dst_hi_q : '0;
    wd1_d  = we1_d ? res_lo_d : '0;
    wd2_d  = we2_d ? res_hi_d : '0;
    busy_d = (state_d != S_IDLE);
    err_d  = reject;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we1_q  <= 1'b0;
      we2_q  <= 1'b0;
      wa1_q  <= '0;
      wa2_q  <= '0;
      wd1_q  <= '0;
      wd2_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      we1_q  <= we1_d;
      we2_q  <= we2_d;
      wa1_q  <= wa1_d;
      wa2_q  <= wa2_d;
      wd1_q  <= wd1_d;
      wd2_q  <= wd2_d;
      busy_q <= busy_d;
      done_q <= we1_d;
      err_q  <= err_d;
    end
  end

  assign vec_io.write_enable_1  = we1_q;
  assign vec_io.write_enable_2  = we2_q;
  assign vec_io.write_address_1 = wa1_q;
  assign vec_io.write_address_2 = wa2_q;
  assign vec_io.input_data_1    = wd1_q;
  assign vec_io.input_data_2    = wd2_q;
  assign vec_io.busy            = busy_q;
  assign vec_io.done            = done_q;
  assign vec_io.err             = err_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq: directed corner cases plus randomized back-to-back traffic.
module tb_vec_alu_seq;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_alu_seq_if vif ();

  vec_alu_seq #(
    .LANES_PER_BEAT (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .vec_io (vif)
  );

  logic [VLEN-1:0] rf [4];
  assign vif.A1 = rf[0];
  assign vif.A2 = rf[1];
  assign vif.A3 = rf[2];
  assign vif.A4 = rf[3];

  typedef struct packed {
    logic            we2;
    logic [1:0]      wa1;
    logic [1:0]      wa2;
    logic [VLEN-1:0] wd1;
    logic [VLEN-1:0] wd2;
  } exp_t;

  exp_t        sb_q [$];
  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned n_done = 0;

  task automatic check_eq(input string tag, input logic [VLEN-1:0] got,
                          input logic [VLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [VLEN-1:0] a,
                                 input logic [VLEN-1:0] b, input logic [1:0] dlo,
                                 input logic [1:0] dhi);
    exp_t              e;
    logic signed [31:0] x, y;
    longint            p;
    e     = '0;
    e.wa1 = dlo;
    e.we2 = (op == 2'b10);
    e.wa2 = e.we2 ? dhi : 2'b00;
    for (int i = 0; i < 16; i++) begin
      x = a[i*32 +: 32];
      y = b[i*32 +: 32];
      p = longint'(x) * longint'(y);
      case (op)
        2'b00: e.wd1[i*32 +: 32] = x + y;
        2'b01: e.wd1[i*32 +: 32] = x - y;
        2'b10: begin
          e.wd1[i*32 +: 32] = p[31:0];
          e.wd2[i*32 +: 32] = p[63:32];
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic logic [8:0] ctl_bits();
    return {vif.write_enable_1, vif.write_enable_2, vif.write_address_1, vif.write_address_2,
            vif.busy, vif.done, vif.err};
  endfunction

  // Write-port monitor: every write must match the oldest outstanding request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (vif.done) n_done++;
    if (vif.write_enable_2 && !vif.write_enable_1)
      check_eq("we2_without_we1", VLEN'(vif.write_enable_2), '0);
    if (vif.write_enable_1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_write", VLEN'(vif.write_enable_1), '0);
      end else begin
        e = sb_q.pop_front();
        check_eq("wr_addr1", VLEN'(vif.write_address_1), VLEN'(e.wa1));
        check_eq("wr_data1", vif.input_data_1, e.wd1);
        check_eq("wr_en2", VLEN'(vif.write_enable_2), VLEN'(e.we2));
        check_eq("wr_data2", vif.input_data_2, e.wd2);
        check_eq("wr_done", VLEN'(vif.done), VLEN'(1'b1));
        if (e.we2) check_eq("wr_addr2", VLEN'(vif.write_address_2), VLEN'(e.wa2));
      end
    end
  end

  // Called at a negedge in an idle cycle; returns at the negedge of the following cycle.
  task automatic issue(input logic [1:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] dlo, input logic [1:0] dhi);
    logic legal;
    legal      = (op != 2'b11) && !(op == 2'b10 && dlo == dhi);
    vif.start  = 1'b1;
    vif.opcode = op;
    vif.src_a  = sa;
    vif.src_b  = sb;
    vif.dst_lo = dlo;
    vif.dst_hi = dhi;
    if (legal) sb_q.push_back(model(op, rf[sa], rf[sb], dlo, dhi));
    @(negedge clk);
    vif.start = 1'b0;
    check_eq("busy_after_start", VLEN'(vif.busy), VLEN'(legal));
    check_eq("err_after_start", VLEN'(vif.err), VLEN'(!legal));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned d0;
    reset      = 1'b1;
    vif.start  = 1'b0;
    vif.opcode = '0;
    vif.src_a  = '0;
    vif.src_b  = '0;
    vif.dst_lo = '0;
    vif.dst_hi = '0;
    for (int r = 0; r < 4; r++) rf[r] = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", VLEN'(ctl_bits()), '0);
    check_eq("reset_data1", vif.input_data_1, '0);
    check_eq("reset_data2", vif.input_data_2, '0);
    reset = 1'b0;
    @(negedge clk);

    // ADD wraps to the most negative value in every lane.
    rf[0] = {16{32'h7FFF_FFFF}};
    rf[1] = {16{32'h0000_0001}};
    d0 = n_done;
    issue(2'b00, 2'd0, 2'd1, 2'd2, 2'd0);
    repeat (3) @(negedge clk);
    check_eq("add_no_early_write", VLEN'(vif.write_enable_1), '0);
    @(negedge clk);
    check_eq("add_we1", VLEN'(vif.write_enable_1), VLEN'(1'b1));
    check_eq("add_wa1", VLEN'(vif.write_address_1), VLEN'(2'd2));
    check_eq("add_we2", VLEN'(vif.write_enable_2), '0);
    check_eq("add_data", vif.input_data_1, {16{32'h8000_0000}});
    check_eq("add_busy_wb", VLEN'(vif.busy), VLEN'(1'b1));
    @(negedge clk);
    check_eq("add_done_once", VLEN'(n_done), VLEN'(d0 + 1));
    check_eq("add_idle_after", VLEN'({vif.busy, vif.done}), '0);

    // Signed MUL with 64-bit product split over both ports.
    for (int l = 0; l < 16; l++) begin
      rf[0][l*32 +: 32] = $urandom;
      rf[3][l*32 +: 32] = $urandom;
    end
    rf[0][31:0]    = 32'hFFFF_FFFD;
    rf[3][31:0]    = 32'd7;
    rf[0][511:480] = 32'h4000_0000;
    rf[3][511:480] = 32'd4;
    issue(2'b10, 2'd0, 2'd3, 2'd1, 2'd3);
    repeat (4) @(negedge clk);
    check_eq("mul_we", VLEN'({vif.write_enable_1, vif.write_enable_2}), VLEN'(2'b11));
    check_eq("mul_l0_lo", VLEN'(vif.input_data_1[31:0]), VLEN'(32'hFFFF_FFEB));
    check_eq("mul_l0_hi", VLEN'(vif.input_data_2[31:0]), VLEN'(32'hFFFF_FFFF));
    check_eq("mul_l15_lo", VLEN'(vif.input_data_1[511:480]), VLEN'(32'h0));
    check_eq("mul_l15_hi", VLEN'(vif.input_data_2[511:480]), VLEN'(32'h1));
    check_eq("mul_wa2", VLEN'(vif.write_address_2), VLEN'(2'd3));
    @(negedge clk);

    // Source/destination aliasing with the register changing after accept.
    for (int l = 0; l < 16; l++) rf[2][l*32 +: 32] = $urandom;
    issue(2'b01, 2'd2, 2'd2, 2'd2, 2'd0);
    @(negedge clk);
    rf[2] = ~rf[2];
    repeat (3) @(negedge clk);
    check_eq("alias_zero", vif.input_data_1, '0);
    check_eq("alias_wa1", VLEN'(vif.write_address_1), VLEN'(2'd2));
    @(negedge clk);

    // Rejections: reserved opcode, then MUL with equal destinations.
    issue(2'b11, 2'd0, 2'd1, 2'd2, 2'd0);
    @(negedge clk);
    check_eq("rsvd_err_pulse", VLEN'({vif.err, vif.busy}), '0);
    issue(2'b10, 2'd0, 2'd1, 2'd1, 2'd1);
    @(negedge clk);
    check_eq("mul_dst_err_pulse", VLEN'({vif.err, vif.busy}), '0);
    repeat (6) @(negedge clk);

    // Start while busy is dropped silently.
    d0 = n_done;
    issue(2'b00, 2'd0, 2'd1, 2'd0, 2'd0);
    @(negedge clk);
    vif.start  = 1'b1;
    vif.opcode = 2'b11;
    @(negedge clk);
    check_eq("busy_no_err_a", VLEN'(vif.err), '0);
    vif.opcode = 2'b00;
    vif.dst_lo = 2'd3;
    @(negedge clk);
    check_eq("busy_no_err_b", VLEN'(vif.err), '0);
    vif.start = 1'b0;
    @(negedge clk);
    check_eq("busy_done_t5", VLEN'(vif.done), VLEN'(1'b1));
    @(negedge clk);
    issue(2'b01, 2'd1, 2'd0, 2'd1, 2'd0);
    repeat (5) @(negedge clk);
    check_eq("busy_done_count", VLEN'(n_done), VLEN'(d0 + 2));

    // Reset in the middle of EXEC discards the operation.
    d0 = n_done;
    issue(2'b10, 2'd1, 2'd0, 2'd0, 2'd2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_eq("rst_mid_ctl", VLEN'(ctl_bits()), '0);
    check_eq("rst_mid_data1", vif.input_data_1, '0);
    check_eq("rst_mid_data2", vif.input_data_2, '0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_mid_no_done", VLEN'(n_done), VLEN'(d0));
    check_eq("rst_mid_idle", VLEN'(vif.busy), '0);

    // Randomized traffic, legal requests issued back-to-back at the earliest slot.
    for (int it = 0; it < 24; it++) begin
      logic [1:0] op, sa, sb, dlo, dhi;
      for (int r = 0; r < 4; r++)
        for (int l = 0; l < 16; l++) rf[r][l*32 +: 32] = $urandom;
      op  = 2'($urandom_range(0, 3));
      sa  = 2'($urandom_range(0, 3));
      sb  = 2'($urandom_range(0, 3));
      dlo = 2'($urandom_range(0, 3));
      dhi = 2'($urandom_range(0, 3));
      issue(op, sa, sb, dlo, dhi);
      if (op != 2'b11 && !(op == 2'b10 && dlo == dhi)) begin
        for (int r = 0; r < 4; r++) rf[r] = ~rf[r];
        repeat (5) @(negedge clk);
      end
    end

    repeat (8) @(negedge clk);
    check_eq("sb_drain", VLEN'(sb_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vec_alu_seq.md
# vec_alu_seq

Multi-cycle elementwise vector ALU sitting directly downstream of the 4×512-bit vector register file. It consumes the register file's four full-register outputs, snapshots two source registers on `start`, processes 16 signed 32-bit lanes over several beats, and drives the register file's two write ports. ADD/SUB results go to write port 1. MUL results split low halves to write port 1 and high halves to write port 2.

## Interface
Parameters:
- `LANES_PER_BEAT`, default 4: lanes computed per EXEC cycle. Legal values are 1, 2, 4, 8, 16.
- `ELEM_W`, default 32: lane width. Fixed by package, not overridable.

Ports:
- `clk`  in  1: single clock, rising-edge logic.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; accepted only in IDLE.
- `opcode`  in  2: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
- `src_a`, `src_b`  in  2 each: source register indices.
- `dst_lo`, `dst_hi`  in  2 each: destination indices; `dst_hi` is used by MUL only.
- `A1`, `A2`, `A3`, `A4`  in  512 each: register file contents (reg 0..3).
- `input_data_1`, `input_data_2`  out  512: write data to the register file.
- `write_address_1`, `write_address_2`  out  2: write addresses.
- `write_enable_1`, `write_enable_2`  out  1: write strobes.
- `busy`  out  1: high from the cycle after accept through the WB cycle.
- `done`  out  1: one-cycle pulse in the WB cycle.
- `err`  out  1: one-cycle pulse the cycle after a rejected request.

## Operation
- States are IDLE, EXEC and WB. `BEATS` = 16 / `LANES_PER_BEAT`.
- IDLE with `start` = 1 and a legal request:
  - Latch `opcode`, `dst_lo` and `dst_hi`.
  - Snapshot the selected `A*` for `src_a` and `src_b` into operand registers.
  - Clear the beat counter and go to EXEC.
- Illegal requests are `opcode` = 11, or MUL with `dst_lo` == `dst_hi`. For these: stay in IDLE, pulse `err` next cycle, issue no write.
- EXEC: each cycle, beat k computes lanes k·LPB .. k·LPB+LPB−1 into result registers. Lane i occupies bits [32i+31:32i]. After beat `BEATS`−1, go to WB.
- WB, one cycle:
  - `write_enable_1` = 1 with `write_address_1` = `dst_lo`.
  - For MUL only: `write_enable_2` = 1 with `write_address_2` = `dst_hi`.
  - `done` = 1, then return to IDLE.
- Arithmetic is two's-complement signed:
  - ADD and SUB wrap modulo 2^32, with no saturation and no flags.
  - MUL forms the full 64-bit signed product. Bits [31:0] go to the lo lane and bits [63:32] to the hi lane.
  - For ADD and SUB, `input_data_2` is 0.
- Operands are snapshotted, so `src` and `dst` may alias, and register-file changes after accept do not affect the result.
- `start` is ignored while busy: no queueing, no `err`.

## Timing
- Accept edge T. EXEC runs at T+1 .. T+`BEATS`; WB is at T+`BEATS`+1, i.e. T+5 with default parameters. Back-to-back requests are accepted at the earliest at T+`BEATS`+2.
- All outputs are registered. Write strobes, addresses and data are stable for the whole WB cycle, which covers the register file's falling-edge write.
- Reset values are 0 for every output: all write enables, addresses and data, `busy`, `done` and `err`. State resets to IDLE.
- Reset in any state returns to IDLE on that edge. The in-flight result is discarded, and no write is issued even if reset coincides with WB.
- `start` coinciding with `reset` is ignored.

## Structure
- Package `vec_pkg` holds:
  - constants `ELEM_W` = 32, `VLEN` = 512, `NUM_LANES` = 16;
  - an opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_RSVD);
  - a state enum (S_IDLE, S_EXEC, S_WB).
- Sub-module `vec_lane_alu`: combinational, one lane, taking (a, b, op) and producing (lo, hi). It is instantiated `LANES_PER_BEAT` times and fed by a beat-indexed lane mux.
- The top level holds the FSM, beat counter, operand snapshot and result registers.

## Test plan
- **ADD wrap.** All lanes of reg0 = 0x7FFFFFFF, reg1 = 1; ADD src 0,1, dst 2 → at T+5, `write_enable_1` = 1, `write_address_1` = 2, every lane 0x80000000; `write_enable_2` = 0; `done` pulses once.
- **MUL signed.** Lane 0 a = −3, b = 7; lane 15 a = 0x40000000, b = 4. Then MUL dst_lo 1, dst_hi 3 gives:
  - lane 0: lo 0xFFFFFFEB, hi 0xFFFFFFFF;
  - lane 15: lo 0x00000000, hi 0x00000001;
  - both write enables high at T+5.
- **Aliasing.** SUB src 2,2, dst 2 while the register-file model rewrites reg2 at T+2 → result is all-zero lanes.
- **Rejection.** `opcode` 11 → `err` at T+1, `busy` stays 0, no write enable. MUL dst_lo = dst_hi = 1 → same response.
- **Busy drop.** A second `start` at T+2 is ignored: exactly one `done`; the next accept succeeds at T+6.
- **Reset mid-operation.** `reset` at T+3 → all outputs 0 at T+4, and no write enable through T+8.
